// File: rtl/gnr_pkg.sv
// Shared FSM encoding and default widths for the attractor search controller.
package gnr_pkg;

    localparam int N_NODES_DEF = 16;
    localparam int CNT_W_DEF   = 32;

    // Result record field widths at default parameters.
    localparam int RES_INIT_W   = N_NODES_DEF;
    localparam int RES_MEET_W   = CNT_W_DEF;
    localparam int RES_PERIOD_W = CNT_W_DEF;
    localparam int RES_STATE_W  = N_NODES_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FWD_A,
        ST_FWD_B,
        ST_FWD_CHK,
        ST_PER_STEP,
        ST_PER_CHK,
        ST_RESULT
    } gnr_state_t;

endpackage

// File: rtl/gnr_step_counter.sv
// Saturating step counter with synchronous clear; limit_hit once count reaches limit.
// Single-cycle update, no backpressure.
module gnr_step_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             limit_hit
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign limit_hit = (count >= limit);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Tortoise/hare attractor search over a sweep of initial states of a Boolean network.
// Latency 2 + 3*meet + 2*period cycles per state; result held until res_ready.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] cfg_first,
    input  logic [CNT_W-1:0]   cfg_num,
    input  logic [CNT_W-1:0]   cfg_max_steps,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic [N_NODES-1:0] res_state,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    gnr_state_t         state_q, state_d;
    logic [N_NODES-1:0] cur_q;
    logic [CNT_W-1:0]   left_q;
    logic [CNT_W-1:0]   max_q;

    logic               m_clr, m_inc, m_hit;
    logic               p_clr, p_inc, p_hit;
    logic [CNT_W-1:0]   m_cnt, p_cnt;

    logic               fwd_eq, per_eq, zero_lim;

    assign fwd_eq   = (s0_vec == s1_vec);
    assign per_eq   = (s1_vec == res_state);
    assign zero_lim = (max_q == '0);
    assign busy     = (state_q != ST_IDLE);

    gnr_step_counter #(.CNT_W(CNT_W)) u_meet_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (m_clr),
        .inc       (m_inc),
        .limit     (max_q),
        .count     (m_cnt),
        .limit_hit (m_hit)
    );

    gnr_step_counter #(.CNT_W(CNT_W)) u_period_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (p_clr),
        .inc       (p_inc),
        .limit     (max_q),
        .count     (p_cnt),
        .limit_hit (p_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        reset_nos  = 1'b0;
        start_s0   = 1'b0;
        start_s1   = 1'b0;
        init_state = '0;
        res_valid  = 1'b0;
        m_clr      = 1'b0;
        m_inc      = 1'b0;
        p_clr      = 1'b0;
        p_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_num == '0) ? ST_IDLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                reset_nos  = 1'b1;
                init_state = cur_q;
                m_clr      = 1'b1;
                state_d    = ST_FWD_A;
            end
            ST_FWD_A: begin
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                state_d  = ST_FWD_B;
            end
            ST_FWD_B: begin
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                m_inc    = 1'b1;
                state_d  = ST_FWD_CHK;
            end
            ST_FWD_CHK: begin
                // A zero limit times out before a meet is even considered.
                if (zero_lim) begin
                    state_d = ST_RESULT;
                end else if (fwd_eq) begin
                    p_clr   = 1'b1;
                    state_d = ST_PER_STEP;
                end else if (m_hit) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_FWD_A;
                end
            end
            ST_PER_STEP: begin
                start_s1 = 1'b1;
                p_inc    = 1'b1;
                state_d  = ST_PER_CHK;
            end
            ST_PER_CHK: begin
                if (per_eq || p_hit) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_PER_STEP;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = (left_q == CNT_W'(1)) ? ST_IDLE : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q       <= '0;
            left_q      <= '0;
            max_q       <= '0;
            res_init    <= '0;
            res_meet    <= '0;
            res_period  <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_q  <= cfg_first;
                        left_q <= cfg_num;
                        max_q  <= cfg_max_steps;
                        done   <= (cfg_num == '0);
                    end
                end
                ST_LOAD: begin
                    res_init    <= cur_q;
                    res_meet    <= '0;
                    res_period  <= '0;
                    res_state   <= '0;
                    res_timeout <= 1'b0;
                end
                ST_FWD_CHK: begin
                    if (zero_lim) begin
                        res_timeout <= 1'b1;
                    end else if (fwd_eq) begin
                        res_meet  <= m_cnt;
                        res_state <= s0_vec;
                    end else if (m_hit) begin
                        res_timeout <= 1'b1;
                    end
                end
                ST_PER_CHK: begin
                    if (per_eq) begin
                        res_period <= p_cnt;
                    end else if (p_hit) begin
                        res_timeout <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        cur_q  <= cur_q + 1'b1;
                        left_q <= left_q - 1'b1;
                        done   <= (left_q == CNT_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: models the node array and the attractor math from the trajectory itself.
module tb_gnr_attractor_ctrl;

    localparam int NN = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] cfg_first;
    logic [CW-1:0] cfg_num;
    logic [CW-1:0] cfg_max_steps;
    logic [NN-1:0] s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1;
    logic [NN-1:0] init_state;
    logic          res_valid, res_ready;
    logic [NN-1:0] res_init, res_state;
    logic [CW-1:0] res_meet, res_period;
    logic          res_timeout, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int net_mode = 0;
    logic [3:0] lut [16];
    logic par = 1'b0;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_first     (cfg_first),
        .cfg_num       (cfg_num),
        .cfg_max_steps (cfg_max_steps),
        .s0_vec        (s0_vec),
        .s1_vec        (s1_vec),
        .reset_nos     (reset_nos),
        .start_s0      (start_s0),
        .start_s1      (start_s1),
        .init_state    (init_state),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_init      (res_init),
        .res_meet      (res_meet),
        .res_period    (res_period),
        .res_state     (res_state),
        .res_timeout   (res_timeout),
        .busy          (busy),
        .done          (done)
    );

    // Network update rules: 0 identity, 1 inverter on node 0, 2 three-node ring,
    // 3 two-bit counter (4-cycle), otherwise a random map on the low four nodes.
    function automatic logic [NN-1:0] f_net(input int mode, input logic [NN-1:0] x);
        case (mode)
            0:       return x;
            1:       return {x[NN-1:1], ~x[0]};
            2:       return {x[NN-1:3], x[1:0], x[2]};
            3:       return {x[NN-1:2], x[1:0] + 2'd1};
            default: return {x[NN-1:4], lut[x[3:0]]};
        endcase
    endfunction

    // Node array: s1 advances every pulse, s0 every second pulse after a load.
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            par    <= 1'b0;
        end else begin
            if (start_s1) s1_vec <= f_net(net_mode, s1_vec);
            if (start_s0) begin
                par <= ~par;
                if (par) s0_vec <= f_net(net_mode, s0_vec);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Reference: first m>=1 with x[m]==x[2m] within the limit, then cycle length at x[m].
    task automatic model(input int mode, input logic [NN-1:0] init, input int maxs,
                         output logic to, output int meet, output int per, output logic [NN-1:0] st);
        logic [NN-1:0] tr [512];
        bit found_m, found_p;
        tr[0] = init;
        for (int k = 1; k < 512; k++) tr[k] = f_net(mode, tr[k-1]);
        to = 1'b1; meet = 0; per = 0; st = '0;
        found_m = 0; found_p = 0;
        if (maxs > 0) begin
            for (int m = 1; m <= maxs && m <= 200; m++) begin
                if (!found_m && tr[m] == tr[2*m]) begin
                    found_m = 1; meet = m; st = tr[m];
                end
            end
        end
        if (found_m) begin
            for (int p = 1; p <= maxs && p <= 100; p++) begin
                if (!found_p && tr[meet+p] == tr[meet]) begin
                    found_p = 1; per = p;
                end
            end
        end
        to = !(found_m && found_p);
    endtask

    task automatic run_sweep(input int mode, input logic [NN-1:0] first, input int num,
                             input int maxs, input bit stall);
        int got, cyc, stall_left, e_meet, e_per;
        bit have_snap;
        logic e_to;
        logic [NN-1:0] e_st, e_init;
        logic [127:0] snap, cur_rec;
        net_mode      = mode;
        cfg_first     = first;
        cfg_num       = CW'(num);
        cfg_max_steps = CW'(maxs);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (num == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_busy", busy, 1'b0);
            chk("zero_valid", res_valid, 1'b0);
            @(negedge clk);
            chk("zero_done_pulse", done, 1'b0);
            chk("zero_valid2", res_valid, 1'b0);
            return;
        end
        chk("busy_start", busy, 1'b1);
        got = 0; cyc = 0; have_snap = 0;
        stall_left = stall ? 10 : 0;
        while (got < num && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (res_valid) begin
                cur_rec = {res_init, res_meet, res_period, res_state, res_timeout};
                if (!have_snap) begin
                    snap = cur_rec; have_snap = 1;
                end else begin
                    chk("res_hold", cur_rec, snap);
                end
                chk("no_pulse", {reset_nos, start_s0, start_s1}, 3'b000);
                if (stall_left > 0) begin
                    res_ready = 1'b0; stall_left--;
                end else begin
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                if (res_ready) begin
                    e_init = first + NN'(got);
                    model(mode, e_init, maxs, e_to, e_meet, e_per, e_st);
                    chk("res_init", res_init, e_init);
                    chk("res_timeout", res_timeout, e_to);
                    if (!e_to) begin
                        chk("res_meet", res_meet, CW'(e_meet));
                        chk("res_period", res_period, CW'(e_per));
                        chk("res_state", res_state, e_st);
                    end
                    got++; have_snap = 0;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
        end
        if (got < num) begin
            chk("sweep_bound", got, num);
            return;
        end
        @(negedge clk);
        res_ready = 1'b0;
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; res_ready = 1'b0;
        cfg_first = '0; cfg_num = '0; cfg_max_steps = '0;
        for (int i = 0; i < 16; i++) lut[i] = 4'(i);
        repeat (3) @(negedge clk);
        chk("rst_outs", {reset_nos, start_s0, start_s1, init_state, res_valid, res_init,
                         res_meet, res_period, res_state, res_timeout, busy, done}, '0);
        rst = 1'b1;
        @(negedge clk);

        run_sweep(0, 16'd5, 1, 100, 1'b1);   // fixed point, stalled consumer
        run_sweep(1, 16'd0, 1, 100, 1'b0);   // inverter
        run_sweep(2, 16'd1, 3, 100, 1'b0);   // three-node ring
        run_sweep(3, 16'd0, 1, 1, 1'b0);     // 4-cycle with limit 1
        run_sweep(0, 16'd7, 0, 100, 1'b0);   // empty sweep
        run_sweep(0, 16'd9, 1, 0, 1'b0);     // zero limit
        run_sweep(0, 16'hFFFF, 2, 10, 1'b0); // state wrap

        // Reset while in FWD_B aborts the sweep.
        net_mode = 3; cfg_first = '0; cfg_num = CW'(1); cfg_max_steps = CW'(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_load", reset_nos, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_fwd_b", {start_s0, start_s1}, 2'b11);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_outs", {reset_nos, start_s0, start_s1, init_state, res_valid, res_init,
                             res_meet, res_period, res_state, res_timeout, busy, done}, '0);
        rst = 1'b1;
        @(negedge clk);
        run_sweep(3, 16'd0, 1, 50, 1'b0);

        for (int t = 0; t < 10; t++) begin
            int maxs;
            for (int i = 0; i < 16; i++) lut[i] = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       maxs = $urandom_range(0, 2);
                1:       maxs = $urandom_range(3, 12);
                default: maxs = 1000;
            endcase
            run_sweep(4, 16'($urandom), $urandom_range(1, 3), maxs, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
